sdf_fft_64pt_ctrl: RTL

SDF_FFT_64PT_CTRL -- requirements
Module: sdf_fft_64pt_ctrl

---
 rtl/sdf_fft_64pt_ctrl.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/sdf_fft_64pt_ctrl.sv
// Control sequencer for a 64-point radix-2 single-delay-feedback FFT: load, five compute stages, drain.
// Optional SDF_CTRL_BITREV_EN reports the drain bin index bit-reversed (natural-order bin number).
module sdf_fft_64pt_ctrl (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   output logic       in_ready,
   output logic       cnt1,
   output logic       cnt2,
   output logic [4:0] mxcv,
   output logic [4:0] mycv,
   output logic       ctrl,
   output logic [4:0] tw_addr,
   output logic [2:0] stage,
   output logic       out_valid,
   output logic       out_last,
   output logic [5:0] out_index,
   output logic       frame_err
);

   typedef enum logic [1:0] {IDLE, LOAD, RUN, DRAIN} state_t;

   state_t     r_state;
   logic [5:0] r_k;
   logic [2:0] r_s;

   state_t     w_nState;
   logic [5:0] w_nK;
   logic [2:0] w_nS;
   logic       w_nErr;

   logic       w_inReady;
   logic       w_cnt1;
   logic       w_cnt2;
   logic [4:0] w_mxcv;
   logic [4:0] w_mycv;
   logic       w_ctrl;
   logic [4:0] w_dMask;
   logic [4:0] w_kMod;
   logic [4:0] w_tw;
   logic [2:0] w_stage;
   logic       w_outValid;
   logic       w_outLast;
   logic [5:0] w_outIndex;

   always_comb begin
      w_nState = r_state;
      w_nK     = r_k;
      w_nS     = r_s;
      w_nErr   = 1'b0;
      case (r_state)
         IDLE: begin
            if (in_valid) begin
               w_nState = LOAD;
               w_nK     = 6'd1;
               w_nS     = 3'd0;
            end
         end
         LOAD: begin
            // A gap in the input stream drops the partial frame.
            if (!in_valid) begin
               w_nState = IDLE;
               w_nK     = 6'd0;
               w_nS     = 3'd0;
               w_nErr   = 1'b1;
            end else if (r_k == 6'd63) begin
               w_nState = RUN;
               w_nK     = 6'd0;
               w_nS     = 3'd1;
            end else begin
               w_nK = r_k + 6'd1;
            end
         end
         RUN: begin
            if (r_k == 6'd63) begin
               w_nK = 6'd0;
               if (r_s == 3'd5) begin
                  w_nState = DRAIN;
                  w_nS     = 3'd0;
               end else begin
                  w_nS = r_s + 3'd1;
               end
            end else begin
               w_nK = r_k + 6'd1;
            end
         end
         DRAIN: begin
            if (r_k == 6'd63) begin
               w_nState = IDLE;
               w_nK     = 6'd0;
               w_nS     = 3'd0;
            end else begin
               w_nK = r_k + 6'd1;
            end
         end
         default: begin
            w_nState = IDLE;
            w_nK     = 6'd0;
            w_nS     = 3'd0;
         end
      endcase
   end

   // Outputs are decoded from the next state so the registered copy lines up with its sample.
   always_comb begin
      w_inReady  = 1'b0;
      w_cnt1     = 1'b0;
      w_cnt2     = 1'b0;
      w_mxcv     = 5'd0;
      w_mycv     = 5'd0;
      w_ctrl     = 1'b1;
      w_tw       = 5'd0;
      w_stage    = 3'd0;
      w_outValid = 1'b0;
      w_outLast  = 1'b0;
      w_outIndex = 6'd0;
      w_dMask    = 5'((6'd32 >> w_nS) - 6'd1);
      w_kMod     = w_nK[4:0] & w_dMask;
      case (w_nState)
         IDLE: begin
            w_inReady = 1'b1;
         end
         LOAD, RUN: begin
            w_inReady = (w_nState == LOAD);
            w_cnt1    = (w_nState == LOAD);
            w_cnt2    = (w_nS == 3'd0);
            for (int j = 0; j < 5; j++) begin
               w_mxcv[j] = (3'(j + 1) > w_nS);
               w_mycv[j] = (3'(j + 1) == w_nS);
            end
            // First half of each 2D group passes through the butterfly.
            w_ctrl  = ~w_nK[3'd5 - w_nS];
            w_tw    = w_ctrl ? 5'd0 : (w_kMod << w_nS);
            w_stage = w_nS;
         end
         DRAIN: begin
            w_stage    = 3'd6;
            w_outValid = 1'b1;
            w_outLast  = (w_nK == 6'd63);
`ifdef SDF_CTRL_BITREV_EN
            for (int b = 0; b < 6; b++) begin
               w_outIndex[b] = w_nK[5 - b];
            end
`else
            w_outIndex = w_nK;
`endif
         end
         default: begin
            w_inReady = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= IDLE;
         r_k       <= 6'd0;
         r_s       <= 3'd0;
         in_ready  <= 1'b1;
         cnt1      <= 1'b0;
         cnt2      <= 1'b0;
         mxcv      <= 5'd0;
         mycv      <= 5'd0;
         ctrl      <= 1'b1;
         tw_addr   <= 5'd0;
         stage     <= 3'd0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         out_index <= 6'd0;
         frame_err <= 1'b0;
      end else begin
         r_state   <= w_nState;
         r_k       <= w_nK;
         r_s       <= w_nS;
         in_ready  <= w_inReady;
         cnt1      <= w_cnt1;
         cnt2      <= w_cnt2;
         mxcv      <= w_mxcv;
         mycv      <= w_mycv;
         ctrl      <= w_ctrl;
         tw_addr   <= w_tw;
         stage     <= w_stage;
         out_valid <= w_outValid;
         out_last  <= w_outLast;
         out_index <= w_outIndex;
         frame_err <= w_nErr;
      end
   end

endmodule
